// File: rtl/add16_pkg.sv
// Shared constants and state type for the 16-bit packet accumulator.
package add16_pkg;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;
    localparam logic [DATA_W-1:0] SAT_VAL = 16'hFFFF;
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_e;
endpackage

// File: rtl/add16_core.sv
// Combinational 16+16 -> 17-bit adder; carry-out is returned separately.
module add16_core
    import add16_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);
    assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

// File: rtl/add16_accum.sv
// Packet accumulator: sums beats until in_last, then holds the result until taken.
// Define ADD16_ACCUM_SAT_EN to saturate the sum at 16'hFFFF instead of wrapping.
module add16_accum
    import add16_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_ovf,
    output logic [CNT_W-1:0]  out_cnt
);
    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [DATA_W-1:0] add_sum;
    logic              add_carry;

    add16_core u_core (
        .a_i     (acc_q),
        .b_i     (in_data),
        .sum_o   (add_sum),
        .carry_o (add_carry)
    );

    // Handshake outputs depend only on registered state.
    assign in_ready  = (state_q == ACC);
    assign out_valid = (state_q == OUT);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;
    assign out_cnt   = cnt_q;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            ACC: begin
                if (in_valid) begin
`ifdef ADD16_ACCUM_SAT_EN
                    // Once saturated, any further add carries or adds zero, so it sticks.
                    acc_d = add_carry ? SAT_VAL : add_sum;
`else
                    acc_d = add_sum;
`endif
                    ovf_d = ovf_q | add_carry;
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
                    if (in_last) state_d = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = ACC;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ACC;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_add16_accum.sv
// Scoreboard bench for add16_accum: stimulus pushes expected packet results, monitor pops on handshake.
module tb_add16_accum;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_last;
    logic [15:0] in_data;
    logic        out_valid, out_ready, out_ovf;
    logic [15:0] out_sum;
    logic [7:0]  out_cnt;

    typedef struct packed {
        logic [15:0] sum;
        logic        ovf;
        logic [7:0]  cnt;
    } res_t;

    res_t exp_q[$];
    int   pop_cyc[$];
    res_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    add16_accum dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic beat(input logic [15:0] d, input logic l);
        int w = 0;
        while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
        if (!in_ready) begin
            n_tests++; n_fail++;
            $display("FAIL beat_wait: in_ready stuck at 0, required 1");
        end
        in_valid = 1'b1; in_data = d; in_last = l;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    function automatic res_t mk(input logic [15:0] s, input logic o, input logic [7:0] c);
        res_t r;
        r.sum = s; r.ovf = o; r.cnt = c;
        return r;
    endfunction

    // Monitor: compare each accepted result against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_result: sum 0x%0h cnt %0d, no result expected", out_sum, out_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_sum", 32'(out_sum), 32'(mon_e.sum));
                chk("res_ovf", 32'(out_ovf), 32'(mon_e.ovf));
                chk("res_cnt", 32'(out_cnt), 32'(mon_e.cnt));
                pop_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready",  32'(in_ready),  1);
        chk("rst_sum",       32'(out_sum),   0);
        chk("rst_ovf",       32'(out_ovf),   0);
        chk("rst_cnt",       32'(out_cnt),   0);
        rst_n = 1'b1;
        idle(1);

        // Basic 3-beat packet, latency 1 and ready again next cycle
        out_ready = 1'b1;
        exp_q.push_back(mk(16'h0006, 1'b0, 8'd3));
        beat(16'h0001, 1'b0);
        chk("partial_sum", 32'(out_sum), 32'h1);
        beat(16'h0002, 1'b0);
        beat(16'h0003, 1'b1);
        chk("lat1_out_valid", 32'(out_valid), 1);
        chk("lat1_in_ready",  32'(in_ready),  0);
        idle(1);
        chk("ready_after_hs", 32'(in_ready), 1);

        // Carry-out packet
`ifdef ADD16_ACCUM_SAT_EN
        exp_q.push_back(mk(16'hFFFF, 1'b1, 8'd2));
`else
        exp_q.push_back(mk(16'h0001, 1'b1, 8'd2));
`endif
        beat(16'hFFFF, 1'b0);
        beat(16'h0002, 1'b1);
        idle(1);

        // Backpressure: result held, incoming beats ignored
        out_ready = 1'b0;
        exp_q.push_back(mk(16'h0030, 1'b0, 8'd2));
        beat(16'h0010, 1'b0);
        beat(16'h0020, 1'b1);
        in_valid = 1'b1; in_data = 16'h7777; in_last = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_out_valid", 32'(out_valid), 1);
            chk("hold_in_ready",  32'(in_ready),  0);
            chk("hold_sum",       32'(out_sum),   32'h30);
            chk("hold_cnt",       32'(out_cnt),   2);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        idle(1);
        chk("cleared_sum", 32'(out_sum), 0);
        exp_q.push_back(mk(16'h0009, 1'b0, 8'd1));
        beat(16'h0009, 1'b1);
        idle(1);

        // 300-beat packet, counter saturates
        exp_q.push_back(mk(16'h012C, 1'b0, 8'd255));
        in_valid = 1'b1; in_data = 16'h0001;
        for (int i = 0; i < 300; i++) begin
            in_last = (i == 299);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_last = 1'b0;
        idle(1);

        // Reset mid-packet discards partial sum
        beat(16'h0005, 1'b0);
        beat(16'h0006, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midrst_sum",       32'(out_sum),   0);
        chk("midrst_cnt",       32'(out_cnt),   0);
        chk("midrst_ovf",       32'(out_ovf),   0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready",  32'(in_ready),  1);
        exp_q.push_back(mk(16'h0005, 1'b0, 8'd1));
        beat(16'h0005, 1'b1);
        idle(1);

        // Back-to-back single-beat packets, one per two cycles
        exp_q.push_back(mk(16'h1234, 1'b0, 8'd1));
        exp_q.push_back(mk(16'h4321, 1'b0, 8'd1));
        in_valid = 1'b1; in_last = 1'b1; in_data = 16'h1234;
        @(posedge clk); #1;
        in_data = 16'h4321;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        idle(2);

        w = 0;
        while (exp_q.size() != 0 && w < 100) begin idle(1); w++; end
        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        if (pop_cyc.size() >= 2)
            chk("b2b_spacing", 32'(pop_cyc[pop_cyc.size()-1] - pop_cyc[pop_cyc.size()-2]), 2);
        else
            chk("b2b_results", 32'(pop_cyc.size()), 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/add16_accum.md
ADD16_ACCUM -- requirements
Module: add16_accum

Interface
REQ-001 Parameter: none; operand width fixed at 16 bits, beat counter fixed at 8 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand beat valid.
REQ-005 in_ready  output  1  block can accept a beat this cycle.
REQ-006 in_data  input  16  operand, unsigned.
REQ-007 in_last  input  1  final beat of the current packet; qualified by in_valid.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  downstream accepts result.
REQ-010 out_sum  output  16  accumulated packet sum.
REQ-011 out_ovf  output  1  sticky flag: at least one add in the packet produced carry-out.
REQ-012 out_cnt  output  8  beats in the packet, saturating at 255.

Function
REQ-013 The block SHALL have two states: ACC and OUT.
REQ-014 In ACC, in_ready SHALL be 1 and out_valid 0.
REQ-015 A beat is accepted when in_valid and in_ready are both 1; only accepted beats change state.
REQ-016 On an accepted beat, acc SHALL become the 16-bit result of acc + in_data; ovf SHALL OR in the carry-out; cnt SHALL increment unless already 255.
REQ-017 An accepted beat with in_last=1 SHALL move the block to OUT on the same edge, so out_valid rises the cycle after the last beat (latency 1).
REQ-018 In OUT, in_ready SHALL be 0 and out_valid 1; out_sum/out_ovf/out_cnt SHALL be stable until the handshake completes.
REQ-019 In OUT, out_valid and out_ready both 1 SHALL return the block to ACC and clear acc, ovf and cnt to 0 on the same edge; the next beat can be accepted the following cycle.
REQ-020 out_ready while in ACC SHALL be ignored; in_valid while in OUT SHALL be ignored and the beat not consumed.
REQ-021 A single-beat packet (in_last on the first beat) SHALL yield out_sum=in_data, out_cnt=1, out_ovf=0.
REQ-022 out_sum, out_ovf and out_cnt SHALL reflect internal acc, ovf and cnt in every state (observable partial sums in ACC, non-qualified).
REQ-023 No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Reset
REQ-024 While rst_n=0 at a rising edge: state<=ACC, acc<=0, ovf<=0, cnt<=0; hence in_ready=1, out_valid=0, out_sum=0, out_ovf=0, out_cnt=0 after the edge.
REQ-025 Reset asserted mid-packet or in OUT SHALL discard the partial or pending result; no beat is accepted on a reset edge.

Configuration
REQ-026 Macro ADD16_ACCUM_SAT_EN: when defined, an add with carry-out SHALL set acc to 16'hFFFF, and acc SHALL stay 16'hFFFF for the rest of the packet.
REQ-027 Without ADD16_ACCUM_SAT_EN, acc SHALL wrap modulo 2^16; out_ovf behaviour SHALL be identical in both builds.

Structure
REQ-028 Shared package add16_pkg SHALL hold the operand width constant (16), the counter width constant (8), the saturation value (16'hFFFF) and the state enum type {ACC, OUT}.
REQ-029 The 16+16 -> 17-bit add SHALL be a separate combinational sub-module add16_core, with {carry, sum[15:0]} outputs and no clock; add16_accum registers its result.
REQ-030 Expected size 120-400 RTL lines total.

Verification
REQ-031 Reset, then beats 0x0001, 0x0002, 0x0003(last), out_ready=1 -> out_valid one cycle after last; sum 0x0006, cnt 3, ovf 0; in_ready=1 the next cycle.
REQ-032 Beats 0xFFFF, 0x0002(last) -> wrap build: sum 0x0001, ovf 1, cnt 2; SAT_EN build: sum 0xFFFF, ovf 1, cnt 2.
REQ-033 Hold out_ready=0 for 5 cycles in OUT while in_valid=1 -> out_* stable, in_ready=0, no beat consumed; first beat after handshake starts from acc=0.
REQ-034 Packet of 300 beats of 0x0001 -> sum 0x012C, cnt 255, ovf 0.
REQ-035 rst_n=0 for one edge after 2 beats of a packet -> all outputs 0, in_ready=1; next packet 0x0005(last) -> sum 0x0005, cnt 1.
REQ-036 Back-to-back single-beat packets 0x1234, 0x4321 with out_ready=1 -> two results 0x1234 and 0x4321, each cnt 1, one packet per two cycles.
